hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Pipeline interlock controller for the 5-stage MIPS core. Tracks destination info for instructions in EX, MEM and WB.
- Detects load-use and taken-branch hazards, and drives PC/IF-ID enables, IF-ID flush and ID-EX bubble insertion.
- Issues registered forwarding selects for the instruction entering EX, using the same 2-bit encoding as the forwarding unit.

Parameters:
- RR_ALU, 3'b000, register-register ALU type code
- RM_ALU, 3'b001, register-immediate ALU type code
- LOAD, 3'b010, load type code
- STORE, 3'b011, store type code
- BRANCH, 3'b100, branch type code
- BR_PENALTY, 2, flush cycles after a taken branch (legal range 1..3)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- id_valid  input  1  ID stage holds a real instruction
- id_type  input  3  type code of ID instruction
- id_rs  input  5  rs field of ID instruction
- id_rt  input  5  rt field of ID instruction
- id_rd  input  5  rd field of ID instruction
- ex_branch_taken  input  1  branch in EX resolved taken (1-cycle pulse)
- mem_busy  input  1  memory not ready; freezes the whole pipeline
- pc_we  output  1  PC write enable
- ifid_we  output  1  IF/ID register write enable
- ifid_flush  output  1  clear IF/ID to NOP
- idex_bubble  output  1  load NOP into ID/EX instead of ID instruction
- fwd_sel_a  output  2  registered mux select for EX operand A (rs)
- fwd_sel_b  output  2  registered mux select for EX operand B (rt)
- stall_cnt  output  16  saturating count of cycles with pc_we=0
- state_o  output  2  FSM state: 0 RUN, 1 LD_STALL, 2 BR_FLUSH

Behaviour:
- Tracking slots S_EX, S_MEM, S_WB, each holding {valid, type, dest, rw}.
  - dest = id_rd if id_type==RR_ALU, else id_rt.
  - rw = id_valid && type in {RR_ALU, RM_ALU, LOAD} && dest!=0.
- Slot advance: when mem_busy=0, S_WB<=S_MEM and S_MEM<=S_EX. S_EX<=ID info, or an invalid slot when idex_bubble=1.
- Freeze: when mem_busy=1, slots, state, counter, fwd_sel_* and stall_cnt all hold. pc_we=ifid_we=ifid_flush=idex_bubble=0.
- Load-use hazard luh (combinational) is true when all of:
  - id_valid=1;
  - S_EX.valid, S_EX.type==LOAD and S_EX.rw;
  - S_EX.dest==id_rs, or S_EX.dest==id_rt with id_type in {RR_ALU, STORE, BRANCH}.
- Outputs are combinational from state, luh, ex_branch_taken and mem_busy, with priority: branch over load-use over normal.
- RUN:
  - If ex_branch_taken: ifid_flush=1, idex_bubble=1, pc_we=1, ifid_we=1. Load cnt=BR_PENALTY-1. Go to BR_FLUSH if BR_PENALTY>1, else stay in RUN.
  - Else if luh: pc_we=0, ifid_we=0, idex_bubble=1. Go to LD_STALL.
  - Else: pc_we=1, ifid_we=1, others 0.
- LD_STALL:
  - Lasts exactly one unfrozen cycle. The load is now in S_MEM and the hazard is resolved.
  - Outputs are as in RUN with luh forced 0. Next state is RUN, or BR_FLUSH on ex_branch_taken (same rule as in RUN).
- BR_FLUSH:
  - ifid_flush=1, idex_bubble=1, pc_we=1, ifid_we=1.
  - cnt decrements each unfrozen cycle. Return to RUN when cnt==1.
  - ex_branch_taken is ignored in this state (EX holds bubbles).
- fwd_sel_a/b update when mem_busy=0. Value is 2'b00 if idex_bubble, else the first match for operand X (rs for A, rt for B):
  - S_EX.rw && S_EX.type!=LOAD && S_EX.dest==X -> 01
  - S_MEM.valid && S_MEM.type==LOAD && S_MEM.rw && S_MEM.dest==X -> 11
  - S_MEM.rw && S_MEM.dest==X -> 10
  - otherwise 00
- stall_cnt: +1 on each unfrozen cycle with pc_we=0; saturates at 16'hFFFF.
- Reset (asynchronous, any time, including mid-stall or mid-flush):
  - state=RUN, cnt=0, all slots invalid, fwd_sel_a=fwd_sel_b=00, stall_cnt=0.
  - Combinational outputs then evaluate to pc_we=1, ifid_we=1, ifid_flush=0, idex_bubble=0.
- Register $0 never creates a hazard or a forward.

Test Plan:
- lw $5,0($1) then add $6,$5,$2: exactly one cycle with pc_we=0 and idex_bubble=1, state_o=1 for one cycle. The add then issues with fwd_sel_a=11 and stall_cnt=1.
- add $3,$1,$2 then sub $4,$3,$3: no stall; fwd_sel_a=01 and fwd_sel_b=01.
- add $3,..; nop; or $7,$3,$0: fwd_sel_a=10 and fwd_sel_b=00.
- lw $0,0($1) then add $6,$0,$0: no stall; fwd_sel_*=00.
- ex_branch_taken pulse with BR_PENALTY=2: ifid_flush=1 and idex_bubble=1 for 2 cycles, then RUN. A simultaneous luh is ignored.
- luh while mem_busy=1 for 3 cycles: all enables 0 and state held. After release, one LD_STALL cycle; stall_cnt=1. Asserting rst during LD_STALL returns state_o=0 and stall_cnt=0 immediately.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Pipeline interlock for the 5-stage MIPS core: load-use stall, taken-branch flush
// and registered forwarding selects for the instruction entering EX.
module hazard_stall_ctrl #(
  parameter logic [2:0] RR_ALU     = 3'b000,
  parameter logic [2:0] RM_ALU     = 3'b001,
  parameter logic [2:0] LOAD       = 3'b010,
  parameter logic [2:0] STORE      = 3'b011,
  parameter logic [2:0] BRANCH     = 3'b100,
  parameter int         BR_PENALTY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [2:0]  id_type,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic        ex_branch_taken,
  input  logic        mem_busy,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic [1:0]  fwd_sel_a,
  output logic [1:0]  fwd_sel_b,
  output logic [15:0] stall_cnt,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LD_STALL = 2'd1,
    ST_BR_FLUSH = 2'd2
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [2:0] typ;
    logic [4:0] dest;
    logic       rw;
  } slot_t;

  localparam logic [1:0] CNT_INIT    = 2'(BR_PENALTY - 1);
  localparam bit         MULTI_FLUSH = (BR_PENALTY > 1);

  state_e      state_q;
  logic [1:0]  cnt_q;
  slot_t       ex_q, ex_d;
  slot_t       mem_q;
  logic [1:0]  fwd_a_q, fwd_a_d;
  logic [1:0]  fwd_b_q, fwd_b_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic        id_writes;
  logic        id_reads_rt;
  logic [4:0]  id_dest;
  logic        luh;

  // The WB-stage destination never influences a stall or forward decision here,
  // so only the EX and MEM occupants are tracked.
  assign id_dest     = (id_type == RR_ALU) ? id_rd : id_rt;
  assign id_writes   = id_valid && (id_dest != 5'd0) &&
                       ((id_type == RR_ALU) || (id_type == RM_ALU) || (id_type == LOAD));
  assign id_reads_rt = (id_type == RR_ALU) || (id_type == STORE) || (id_type == BRANCH);

  assign luh = id_valid && ex_q.valid && (ex_q.typ == LOAD) && ex_q.rw &&
               ((ex_q.dest == id_rs) || (id_reads_rt && (ex_q.dest == id_rt)));

  function automatic logic [1:0] fwd_for(input logic [4:0] x, input slot_t ex,
                                         input slot_t mem);
    logic [1:0] sel;
    sel = 2'b00;
    if (ex.rw && (ex.typ != LOAD) && (ex.dest == x))
      sel = 2'b01;
    else if (mem.valid && (mem.typ == LOAD) && mem.rw && (mem.dest == x))
      sel = 2'b11;
    else if (mem.rw && (mem.dest == x))
      sel = 2'b10;
    return sel;
  endfunction

  always_comb begin
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (!mem_busy) begin
      case (state_q)
        ST_BR_FLUSH: begin
          pc_we       = 1'b1;
          ifid_we     = 1'b1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end
        default: begin
          if (ex_branch_taken) begin
            pc_we       = 1'b1;
            ifid_we     = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (luh && (state_q == ST_RUN)) begin
            idex_bubble = 1'b1;
          end else begin
            pc_we   = 1'b1;
            ifid_we = 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    ex_d = '0;
    if (!idex_bubble) begin
      ex_d.valid = id_valid;
      ex_d.typ   = id_type;
      ex_d.dest  = id_dest;
      ex_d.rw    = id_writes;
    end
    fwd_a_d     = idex_bubble ? 2'b00 : fwd_for(id_rs, ex_q, mem_q);
    fwd_b_d     = idex_bubble ? 2'b00 : fwd_for(id_rt, ex_q, mem_q);
    stall_cnt_d = stall_cnt_q;
    if (!pc_we && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      cnt_q       <= 2'd0;
      ex_q        <= '0;
      mem_q       <= '0;
      fwd_a_q     <= 2'b00;
      fwd_b_q     <= 2'b00;
      stall_cnt_q <= 16'd0;
    end else if (!mem_busy) begin
      mem_q       <= ex_q;
      ex_q        <= ex_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
      case (state_q)
        ST_BR_FLUSH: begin
          cnt_q <= cnt_q - 2'd1;
          if (cnt_q == 2'd1)
            state_q <= ST_RUN;
        end
        default: begin
          // EX holds a bubble after a load-use stall, so LD_STALL never re-stalls.
          if (ex_branch_taken) begin
            cnt_q   <= CNT_INIT;
            state_q <= MULTI_FLUSH ? ST_BR_FLUSH : ST_RUN;
          end else if (luh && (state_q == ST_RUN)) begin
            state_q <= ST_LD_STALL;
          end else begin
            state_q <= ST_RUN;
          end
        end
      endcase
    end
  end

  assign fwd_sel_a = fwd_a_q;
  assign fwd_sel_b = fwd_b_q;
  assign stall_cnt = stall_cnt_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed pipeline scenarios plus randomized traffic
// checked against an instruction-level model of the interlock rules.
module tb_hazard_stall_ctrl;
  localparam logic [2:0] T_RR = 3'd0, T_RM = 3'd1, T_LD = 3'd2, T_ST = 3'd3, T_BR = 3'd4;
  localparam int PEN = 2;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, ex_branch_taken, mem_busy;
  logic [2:0] id_type;
  logic [4:0] id_rs, id_rt, id_rd;
  logic pc_we, ifid_we, ifid_flush, idex_bubble;
  logic [1:0] fwd_sel_a, fwd_sel_b, state_o;
  logic [15:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.BR_PENALTY(PEN)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_type(id_type), .id_rs(id_rs),
    .id_rt(id_rt), .id_rd(id_rd), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .stall_cnt(stall_cnt), .state_o(state_o)
  );

  // Model: what instruction occupies EX/MEM, and how many flush cycles remain.
  typedef struct {bit valid; bit load; int wreg;} instr_t;
  instr_t m_ex, m_mem;
  int m_flush_left;
  bit m_after_stall;
  int m_stalls;
  logic [1:0] m_fa, m_fb;

  function automatic logic [1:0] m_fwd(int x);
    if (x == 0) return 2'd0;
    if (m_ex.valid && !m_ex.load && m_ex.wreg == x) return 2'd1;
    if (m_mem.valid && m_mem.wreg == x) return m_mem.load ? 2'd3 : 2'd2;
    return 2'd0;
  endfunction

  task automatic model_reset();
    m_ex = '{0, 0, 0};
    m_mem = '{0, 0, 0};
    m_flush_left = 0;
    m_after_stall = 0;
    m_stalls = 0;
    m_fa = 0;
    m_fb = 0;
  endtask

  task automatic drive(input bit v, input logic [2:0] t, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input bit br, input bit busy);
    id_valid = v; id_type = t; id_rs = rs; id_rt = rt; id_rd = rd;
    ex_branch_taken = br; mem_busy = busy;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1, T_LD, 1, 5, 0, 0, 0);
    @(negedge clk); #1;
    checks++; if (pc_we !== 1'b1) begin failures++; $display("FAIL reset_pc_we: got %b expected 1", pc_we); end
    checks++; if (ifid_we !== 1'b1) begin failures++; $display("FAIL reset_ifid_we: got %b expected 1", ifid_we); end
    checks++; if (ifid_flush !== 1'b0 || idex_bubble !== 1'b0) begin failures++; $display("FAIL reset_flush_bubble: got %b%b expected 00", ifid_flush, idex_bubble); end
    checks++; if (state_o !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", state_o); end
    checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
    checks++; if (fwd_sel_a !== 2'd0 || fwd_sel_b !== 2'd0) begin failures++; $display("FAIL reset_fwd: got %0d/%0d expected 0/0", fwd_sel_a, fwd_sel_b); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, T_LD, 1, 5, 0, 0, 0); #1;
    checks++; if (pc_we !== 1'b1 || idex_bubble !== 1'b0) begin failures++; $display("FAIL lu_issue_lw: got pc_we=%b bubble=%b expected 1/0", pc_we, idex_bubble); end
    @(negedge clk);
    drive(1, T_RR, 5, 2, 6, 0, 0); #1;
    checks++; if (pc_we !== 1'b0 || ifid_we !== 1'b0) begin failures++; $display("FAIL lu_stall_we: got pc_we=%b ifid_we=%b expected 0/0", pc_we, ifid_we); end
    checks++; if (idex_bubble !== 1'b1 || ifid_flush !== 1'b0) begin failures++; $display("FAIL lu_stall_bubble: got bubble=%b flush=%b expected 1/0", idex_bubble, ifid_flush); end
    @(negedge clk); #1;
    checks++; if (state_o !== 2'd1) begin failures++; $display("FAIL lu_state: got %0d expected 1", state_o); end
    checks++; if (pc_we !== 1'b1 || idex_bubble !== 1'b0) begin failures++; $display("FAIL lu_release: got pc_we=%b bubble=%b expected 1/0", pc_we, idex_bubble); end
    checks++; if (stall_cnt !== 16'd1) begin failures++; $display("FAIL lu_stall_cnt: got %0d expected 1", stall_cnt); end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0); #1;
    checks++; if (fwd_sel_a !== 2'b11 || fwd_sel_b !== 2'b00) begin failures++; $display("FAIL lu_fwd: got %b/%b expected 11/00", fwd_sel_a, fwd_sel_b); end
    checks++; if (state_o !== 2'd0) begin failures++; $display("FAIL lu_back_to_run: got %0d expected 0", state_o); end
    @(negedge clk);
  endtask

  task automatic test_ex_forward();
    idle(2);
    drive(1, T_RR, 1, 2, 3, 0, 0);
    @(negedge clk);
    drive(1, T_RR, 3, 3, 4, 0, 0); #1;
    checks++; if (pc_we !== 1'b1 || idex_bubble !== 1'b0) begin failures++; $display("FAIL exf_no_stall: got pc_we=%b bubble=%b expected 1/0", pc_we, idex_bubble); end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0); #1;
    checks++; if (fwd_sel_a !== 2'b01 || fwd_sel_b !== 2'b01) begin failures++; $display("FAIL exf_fwd: got %b/%b expected 01/01", fwd_sel_a, fwd_sel_b); end
    @(negedge clk);
  endtask

  task automatic test_mem_forward();
    idle(2);
    drive(1, T_RR, 1, 2, 3, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, T_RR, 3, 0, 7, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0); #1;
    checks++; if (fwd_sel_a !== 2'b10 || fwd_sel_b !== 2'b00) begin failures++; $display("FAIL memf_fwd: got %b/%b expected 10/00", fwd_sel_a, fwd_sel_b); end
    @(negedge clk);
  endtask

  task automatic test_zero_reg();
    idle(2);
    drive(1, T_LD, 1, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, T_RR, 0, 0, 6, 0, 0); #1;
    checks++; if (pc_we !== 1'b1 || idex_bubble !== 1'b0) begin failures++; $display("FAIL zero_no_stall: got pc_we=%b bubble=%b expected 1/0", pc_we, idex_bubble); end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0); #1;
    checks++; if (fwd_sel_a !== 2'b00 || fwd_sel_b !== 2'b00) begin failures++; $display("FAIL zero_fwd: got %b/%b expected 00/00", fwd_sel_a, fwd_sel_b); end
    checks++; if (stall_cnt !== 16'd1) begin failures++; $display("FAIL zero_stall_cnt: got %0d expected 1", stall_cnt); end
    @(negedge clk);
  endtask

  task automatic test_branch();
    idle(2);
    drive(1, T_LD, 1, 5, 0, 0, 0);
    @(negedge clk);
    drive(1, T_RR, 5, 2, 6, 1, 0); #1;
    checks++; if ({pc_we, ifid_we, ifid_flush, idex_bubble} !== 4'b1111) begin failures++; $display("FAIL br_first: got %b expected 1111", {pc_we, ifid_we, ifid_flush, idex_bubble}); end
    checks++; if (state_o !== 2'd0) begin failures++; $display("FAIL br_first_state: got %0d expected 0", state_o); end
    @(negedge clk); #1;
    checks++; if (state_o !== 2'd2) begin failures++; $display("FAIL br_flush_state: got %0d expected 2", state_o); end
    checks++; if ({pc_we, ifid_we, ifid_flush, idex_bubble} !== 4'b1111) begin failures++; $display("FAIL br_second: got %b expected 1111", {pc_we, ifid_we, ifid_flush, idex_bubble}); end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0); #1;
    checks++; if (state_o !== 2'd0 || ifid_flush !== 1'b0 || idex_bubble !== 1'b0) begin failures++; $display("FAIL br_done: got state=%0d flush=%b bubble=%b expected 0/0/0", state_o, ifid_flush, idex_bubble); end
    checks++; if (stall_cnt !== 16'd1) begin failures++; $display("FAIL br_stall_cnt: got %0d expected 1", stall_cnt); end
    @(negedge clk);
  endtask

  task automatic test_busy_stall_reset();
    do_reset();
    drive(1, T_LD, 1, 5, 0, 0, 0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      drive(1, T_RR, 5, 2, 6, 0, 1); #1;
      checks++; if ({pc_we, ifid_we, ifid_flush, idex_bubble} !== 4'b0000) begin failures++; $display("FAIL busy_outputs[%0d]: got %b expected 0000", i, {pc_we, ifid_we, ifid_flush, idex_bubble}); end
      checks++; if (state_o !== 2'd0 || stall_cnt !== 16'd0) begin failures++; $display("FAIL busy_hold[%0d]: got state=%0d cnt=%0d expected 0/0", i, state_o, stall_cnt); end
      @(negedge clk);
    end
    drive(1, T_RR, 5, 2, 6, 0, 0); #1;
    checks++; if (pc_we !== 1'b0 || idex_bubble !== 1'b1) begin failures++; $display("FAIL busy_release: got pc_we=%b bubble=%b expected 0/1", pc_we, idex_bubble); end
    @(negedge clk); #1;
    checks++; if (state_o !== 2'd1 || stall_cnt !== 16'd1) begin failures++; $display("FAIL busy_ldstall: got state=%0d cnt=%0d expected 1/1", state_o, stall_cnt); end
    rst = 1'b1; #1;
    checks++; if (state_o !== 2'd0 || stall_cnt !== 16'd0) begin failures++; $display("FAIL async_reset: got state=%0d cnt=%0d expected 0/0", state_o, stall_cnt); end
    checks++; if ({pc_we, ifid_we, ifid_flush, idex_bubble} !== 4'b1100) begin failures++; $display("FAIL async_reset_out: got %b expected 1100", {pc_we, ifid_we, ifid_flush, idex_bubble}); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic e_pc, e_ifid, e_flush, e_bub;
    logic [1:0] e_state;
    bit v, br, busy, haz, reads_rt;
    logic [2:0] t;
    logic [4:0] rs, rt, rd;
    int wreg;
    do_reset();
    model_reset();
    for (int n = 0; n < 4000; n++) begin
      v = ($urandom_range(0, 99) < 85);
      t = 3'($urandom_range(0, 4));
      rs = 5'($urandom_range(0, 3));
      rt = 5'($urandom_range(0, 3));
      rd = 5'($urandom_range(0, 3));
      br = ($urandom_range(0, 99) < 12);
      busy = ($urandom_range(0, 99) < 15);
      drive(v, t, rs, rt, rd, br, busy);
      #1;
      wreg = (v && t <= T_LD) ? ((t == T_RR) ? int'(rd) : int'(rt)) : 0;
      reads_rt = (t == T_RR) || (t == T_ST) || (t == T_BR);
      haz = v && m_ex.valid && m_ex.load && m_ex.wreg != 0 &&
            (m_ex.wreg == int'(rs) || (reads_rt && m_ex.wreg == int'(rt)));
      if (busy) {e_pc, e_ifid, e_flush, e_bub} = 4'b0000;
      else if (m_flush_left > 0 || br) {e_pc, e_ifid, e_flush, e_bub} = 4'b1111;
      else if (haz && !m_after_stall) {e_pc, e_ifid, e_flush, e_bub} = 4'b0001;
      else {e_pc, e_ifid, e_flush, e_bub} = 4'b1100;
      e_state = (m_flush_left > 0) ? 2'd2 : (m_after_stall ? 2'd1 : 2'd0);
      checks++; if ({pc_we, ifid_we, ifid_flush, idex_bubble} !== {e_pc, e_ifid, e_flush, e_bub}) begin failures++; $display("FAIL rnd_ctrl cyc=%0d: got %b expected %b", n, {pc_we, ifid_we, ifid_flush, idex_bubble}, {e_pc, e_ifid, e_flush, e_bub}); end
      checks++; if (state_o !== e_state) begin failures++; $display("FAIL rnd_state cyc=%0d: got %0d expected %0d", n, state_o, e_state); end
      checks++; if (fwd_sel_a !== m_fa || fwd_sel_b !== m_fb) begin failures++; $display("FAIL rnd_fwd cyc=%0d: got %b/%b expected %b/%b", n, fwd_sel_a, fwd_sel_b, m_fa, m_fb); end
      checks++; if (stall_cnt !== 16'(m_stalls)) begin failures++; $display("FAIL rnd_stall_cnt cyc=%0d: got %0d expected %0d", n, stall_cnt, m_stalls); end
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1; #1;
        model_reset();
        checks++; if (state_o !== 2'd0 || stall_cnt !== 16'd0 || fwd_sel_a !== 2'd0) begin failures++; $display("FAIL rnd_reset cyc=%0d: got state=%0d cnt=%0d fa=%0d expected 0/0/0", n, state_o, stall_cnt, fwd_sel_a); end
        @(negedge clk);
        rst = 1'b0;
        continue;
      end
      if (!busy) begin
        m_fa = e_bub ? 2'd0 : m_fwd(int'(rs));
        m_fb = e_bub ? 2'd0 : m_fwd(int'(rt));
        if (m_flush_left > 0) begin
          m_flush_left--;
          m_after_stall = 0;
        end else if (br) begin
          m_flush_left = PEN - 1;
          m_after_stall = 0;
        end else begin
          m_after_stall = haz && !m_after_stall;
        end
        if (!e_pc && m_stalls < 65535) m_stalls++;
        m_mem = m_ex;
        if (e_bub) m_ex = '{0, 0, 0};
        else m_ex = '{v, (t == T_LD), wreg};
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    test_reset();
    test_load_use();
    test_ex_forward();
    test_mem_forward();
    test_zero_reg();
    test_branch();
    test_busy_stall_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
